// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state type and default parameters for the PC sequencer
package pc_sequencer_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam int DEF_RAS_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake and redirect bus between sequencer and fetch/branch logic
interface pc_sequencer_if import pc_sequencer_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] br_target;
  logic pc_valid;
  logic pc_ready;
  logic br_en;
  logic call_en;
  logic ret_en;
  modport master (output pc_out, pc_valid, input pc_ready, br_en, call_en, ret_en, br_target);
  modport slave (input pc_out, pc_valid, output pc_ready, br_en, call_en, ret_en, br_target);
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: pointer-based return-address LIFO; pushes when full and pops when empty are dropped
module ras_stack import pc_sequencer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] top;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign top = cnt_q[AW-1:0] - AW'(1);
  assign dout = mem[top];
  // pop takes precedence if both are requested
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && !pop && !full;
    cnt_d = do_pop ? cnt_q - (AW+1)'(1) : do_push ? cnt_q + (AW+1)'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  always_ff @(posedge clk)
    if (do_push) mem[cnt_q[AW-1:0]] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with fetch handshake, branch/call/return redirects and run control
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter int             WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter int             RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           halt,
  input  logic           resume,
  pc_sequencer_if.master bus,
  output logic           ras_ovf,
  output logic           ras_udf,
  output logic           busy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic push, pop, ras_full, ras_empty;
  assign pc_inc = pc_q + WIDTH'(1);
  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pc_inc),
    .dout(ras_top), .full(ras_full), .empty(ras_empty)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    valid_d = 1'b0;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        valid_d = 1'b1;
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      RUN: begin
        pop = bus.ret_en && !ras_empty;
        push = !bus.ret_en && bus.call_en;
        udf_d = udf_q || (bus.ret_en && ras_empty);
        ovf_d = ovf_q || (push && ras_full);
        // ret > call > branch > accepted fetch > hold
        pc_d = bus.ret_en ? (ras_empty ? pc_q : ras_top) :
               (bus.call_en || bus.br_en) ? bus.br_target :
               (valid_q && bus.pc_ready) ? pc_inc : pc_q;
        state_d = halt ? HALT : RUN;
        valid_d = !halt;
      end
      HALT: begin
        state_d = (resume && !halt) ? RUN : HALT;
        valid_d = resume && !halt;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      pc_q <= RESET_VEC;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign bus.pc_out = pc_q;
  assign bus.pc_valid = valid_q;
  assign ras_ovf = ovf_q;
  assign ras_udf = udf_q;
  assign busy = state_q == RUN;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the general-purpose processor. It holds the current instruction address and offers it to the fetch stage over a valid/ready handshake. On each accepted fetch it advances the address by one, modulo 2^WIDTH. It also applies branch, call and return redirects, using an internal return-address stack (RAS), and supports start/halt/resume control from the control unit.

## Interface
- WIDTH, 16, address width in bits
- RESET_VEC, 16'h0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  leave IDLE and begin fetching
- halt  in  1  request stop (RUN → HALT)
- resume  in  1  restart from HALT
- pc_ready  in  1  fetch stage accepts pc_out this cycle
- br_en  in  1  branch redirect to br_target
- call_en  in  1  push return address, redirect to br_target
- ret_en  in  1  pop RAS top into PC
- br_target  in  WIDTH  redirect target address
- pc_out  out  WIDTH  current PC, registered
- pc_valid  out  1  pc_out is offered to fetch, registered
- ras_ovf  out  1  sticky: push attempted while RAS full
- ras_udf  out  1  sticky: pop attempted while RAS empty
- busy  out  1  high in RUN

## Operation
- **FSM states:** IDLE, RUN, HALT.
- **Reset:** pc_out=RESET_VEC, pc_valid=0, state=IDLE, RAS empty, ras_ovf=0, ras_udf=0, busy=0.
- **IDLE:**
  - start → RUN.
  - pc_valid=0.
  - Redirect inputs are ignored.
  - start also clears ras_ovf and ras_udf.
- **RUN:**
  - pc_valid=1.
  - Next-PC priority, highest first: ret_en > call_en > br_en > accepted handshake (pc_valid & pc_ready) > hold.
  - **ret_en:**
    - Non-empty RAS: pc ← RAS top; pop.
    - Empty RAS: pc holds, ras_udf←1.
  - **call_en:**
    - Push pc_out+1 (mod 2^WIDTH), then pc ← br_target.
    - Full RAS: push dropped, ras_ovf←1, jump still taken.
  - **br_en:** pc ← br_target.
  - **Sequential:** pc ← pc_out+1. 16'hFFFF wraps to 16'h0000; no carry out, no flag.
  - If a handshake and a redirect coincide, the fetch of the current pc_out counts as consumed and the redirect wins.
  - halt → HALT. Any redirect or advance in the same cycle still applies first.
- **HALT:**
  - pc_valid=0; pc holds.
  - Redirects are ignored.
  - resume → RUN.
  - halt and resume together: stay in HALT.
- **Reset mid-operation:** immediate return to reset values from any state. RAS contents are discarded.

## Timing
- All outputs are registered; no combinational input→output path.
- Redirect latency is 1 cycle: the target appears on pc_out on the edge after the request.
- Sequential advance is 1 cycle after the accepted handshake.
- **Stall:** while pc_valid=1 and pc_ready=0 with no redirect, pc_out is stable.
- A redirect may change pc_out while a fetch is unaccepted. The fetch stage must treat the new value as authoritative.
- start→first pc_valid=1: 1 cycle.
- halt→pc_valid=0: 1 cycle.
- resume→pc_valid=1: 1 cycle.
- ras_ovf/ras_udf update 1 cycle after the offending request. They clear only on reset or start.

## Structure
- **Shared package:** state enum {IDLE, RUN, HALT}, default WIDTH, RESET_VEC, RAS_DEPTH.
- **Sub-module ras_stack:** parameterised LIFO (WIDTH, RAS_DEPTH).
  - Ports: push, pop, din, dout (top), full, empty; async active-low reset.
  - Pointer-based; no data shift.
- **Next-PC logic:** combinational priority mux into the PC register. The +1 adder is inline and combinational so the advance is single-cycle.

## Test plan
- **Reset/start:** rst low, release, start pulse, pc_ready=1 → pc_out 0,1,2,3 on successive cycles. pc_valid rises 1 cycle after start.
- **Stall and wrap:**
  - Branch to 16'hFFFE, pc_ready=1 → sequence FFFE, FFFF, 0000.
  - pc_ready=0 for 3 cycles at 0x0005 → pc_out holds 0x0005.
- **Call/return nesting:**
  - call to 0x0100 from 0x0010, then call to 0x0200 from 0x0102.
  - ret → 0x0103; ret → 0x0011.
  - ras_ovf=0 and ras_udf=0 throughout.
- **RAS boundaries:**
  - 5 calls with RAS_DEPTH=4 → ras_ovf=1 after the 5th; the 5th jump is still taken.
  - 5 rets → 4 correct returns; the 5th holds pc with ras_udf=1.
  - start from IDLE (after reset) clears both flags.
- **Simultaneous events:**
  - ret_en+call_en+br_en in one cycle → ret wins, RAS depth −1.
  - br_en with pc_ready=1 → target wins.
  - halt with br_en → pc_out=target, pc_valid=0 next cycle; resume → pc_valid=1 with the same pc.
- **Async reset mid-RUN:** assert rst between clock edges at pc=0x0042 → pc_out=RESET_VEC, pc_valid=0 immediately, state IDLE, RAS empty.
